// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus the reserved opcode range the decoder may still emit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_MATCH = 4'd1,
        OP_LT    = 4'd2,
        OP_DIST  = 4'd3,
        OP_LSL   = 4'd4,
        OP_LSR   = 4'd5,
        OP_INCR  = 4'd6,
        OP_AND1  = 4'd7,
        OP_EQZ   = 4'd8,
        OP_ZERO  = 4'd9,
        OP_MUL   = 4'd10,
        OP_FLAG  = 4'd11
    } op_t;

    // State names carry a prefix so they cannot collide with the opcode names.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_RSVD_LO = 4'd12;
    localparam logic [3:0] OP_RSVD_HI = 4'd15;

    function automatic logic is_reserved(input logic [3:0] code);
        return (code >= OP_RSVD_LO);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per step,
// WIDTH steps per product. Sequencing is owned by the parent FSM.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     partial;
    logic [CW-1:0]      count;

    // Add the gated multiplicand into the upper half, then shift the whole
    // accumulator right; after WIDTH steps it holds the full product.
    always_comb begin
        partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_next = {partial, acc[WIDTH-1:1]};
    end

    // product is the value this step commits, so the parent can capture the
    // final result on the same edge as the last iteration.
    assign product = acc_next;
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            mplier <= mplier >> 1;
            acc    <= acc_next;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle ops, an iterative multiply behind a
// start/busy/done handshake, and the architectural flag register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    state_t               state;
    logic                 accept;
    logic                 mul_load;
    logic                 mul_step;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     next_result;
    logic                 next_flag;
    logic                 lt;
    logic [WIDTH:0]       diff;
    logic [WIDTH:0]       mag;
    logic                 reserved;

    assign accept   = start && (state == S_IDLE);
    assign mul_load = accept && (op == OP_MUL);
    assign mul_step = (state == S_MUL);
    assign reserved = is_reserved(op);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (in1),
        .mplier_in (in2),
        .last      (mul_last),
        .product   (product)
    );

    // Signed distance is formed one bit wider so |a-b| never overflows.
    always_comb begin
        lt   = ($signed(in1) < $signed(in2));
        diff = {in1[WIDTH-1], in1} - {in2[WIDTH-1], in2};
        mag  = diff[WIDTH] ? (~diff + ONE_X) : diff;
    end

    always_comb begin
        next_result = result;
        next_flag   = flag;
        if (!reserved) begin
            case (op)
                OP_ADD:   {next_flag, next_result} = {1'b0, in1} + {1'b0, in2};
                OP_MATCH: next_flag = (in1 == in2);
                OP_LT:    next_flag = lt;
                OP_DIST: begin
                    next_result = mag[WIDTH-1:0];
                    next_flag   = lt;
                end
                OP_LSL: begin
                    next_result = {in2[WIDTH-2:0], 1'b0};
                    next_flag   = in2[WIDTH-1];
                end
                OP_LSR: begin
                    next_result = {1'b0, in2[WIDTH-1:1]};
                    next_flag   = in2[0];
                end
                OP_INCR:  {next_flag, next_result} = {1'b0, in2} + ONE_X;
                OP_AND1:  next_flag = in2[0];
                OP_EQZ:   next_flag = (in2 == '0);
                OP_ZERO: begin
                    next_result = '0;
                    next_flag   = 1'b0;
                end
                OP_FLAG:  next_result = {{(WIDTH-1){1'b0}}, flag};
                default: begin
                    next_result = result;
                    next_flag   = flag;
                end
            endcase
        end
    end

    // Starts arriving while a multiply runs are dropped, never queued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            result <= '0;
            flag   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                        end else begin
                            result <= next_result;
                            flag   <= next_flag;
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        result <= product[WIDTH-1:0];
                        flag   <= |product[2*WIDTH-1:WIDTH];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of single-cycle ops followed
// by hand-written multiply, back-to-back and reset-abort sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       flag;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_result;
        logic       exp_flag;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    alu_seq #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flag    (flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        op    = o;
        in1   = a;
        in2   = b;
        start = 1'b1;
    endtask

    task automatic check_done(input string tag, input logic [7:0] r, input logic f);
        check_output({tag, "_done"}, 8'(done), 8'd1);
        check_output({tag, "_busy"}, 8'(busy), 8'd0);
        check_output({tag, "_result"}, result, r);
        check_output({tag, "_flag"}, 8'(flag), 8'(f));
    endtask

    // Runs one multiply from the current negedge; optionally pokes an ADD 1+1
    // every busy cycle to show it is dropped.
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic f, input logic inject);
        apply_stimulus(OP_MUL, a, b);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_output($sformatf("%s_busy_c%0d", tag, k), 8'(busy), 8'd1);
            check_output($sformatf("%s_nodone_c%0d", tag, k), 8'(done), 8'd0);
            if (inject) apply_stimulus(OP_ADD, 8'h01, 8'h01);
            @(negedge clock);
        end
        start = 1'b0;
        check_done(tag, r, f);
        @(negedge clock);
        check_output({tag, "_single_pulse"}, 8'(done), 8'd0);
        check_output({tag, "_held"}, result, r);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1]  = '{OP_MATCH, 8'h5A, 8'h5A, 8'h00, 1'b1};
        vecs[2]  = '{OP_DIST,  8'h7F, 8'h80, 8'hFF, 1'b0};
        vecs[3]  = '{OP_DIST,  8'h80, 8'h7F, 8'hFF, 1'b1};
        vecs[4]  = '{OP_LT,    8'h01, 8'h80, 8'hFF, 1'b0};
        vecs[5]  = '{OP_LT,    8'h80, 8'h01, 8'hFF, 1'b1};
        vecs[6]  = '{OP_ADD,   8'h12, 8'h34, 8'h46, 1'b0};
        vecs[7]  = '{OP_EQZ,   8'h33, 8'h00, 8'h46, 1'b1};
        vecs[8]  = '{OP_FLAG,  8'h00, 8'h00, 8'h01, 1'b1};
        vecs[9]  = '{OP_AND1,  8'h00, 8'h02, 8'h01, 1'b0};
        vecs[10] = '{OP_LSL,   8'h00, 8'hC3, 8'h86, 1'b1};
        vecs[11] = '{OP_LSR,   8'h00, 8'h02, 8'h01, 1'b0};
        vecs[12] = '{OP_INCR,  8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[13] = '{4'd12,    8'hAA, 8'h55, 8'h00, 1'b1};
        vecs[14] = '{OP_MATCH, 8'h12, 8'h13, 8'h00, 1'b0};
        vecs[15] = '{OP_INCR,  8'h00, 8'h41, 8'h42, 1'b0};
        vecs[16] = '{4'd15,    8'hFF, 8'hFF, 8'h42, 1'b0};
        vecs[17] = '{OP_ZERO,  8'h9C, 8'h63, 8'h00, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 4'd0;
        in1     = 8'h00;
        in2     = 8'h00;

        // Inputs churn randomly while reset is held; outputs must stay cleared.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            start = 1'b1;
            op    = 4'($urandom);
            in1   = 8'($urandom);
            in2   = 8'($urandom);
            check_output($sformatf("reset%0d_result", i), result, 8'h00);
            check_output($sformatf("reset%0d_flag", i), 8'(flag), 8'd0);
            check_output($sformatf("reset%0d_busy", i), 8'(busy), 8'd0);
            check_output($sformatf("reset%0d_done", i), 8'(done), 8'd0);
        end
        @(negedge clock);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        // Table vectors issue back-to-back, so done is expected every cycle.
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clock);
            start = 1'b0;
            check_done($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_flag);
        end
        @(negedge clock);
        check_output("idle_no_done", 8'(done), 8'd0);

        run_mul("mul_15x17", 8'd15, 8'd17, 8'hFF, 1'b0, 1'b0);
        run_mul("mul_16x16", 8'd16, 8'd16, 8'h00, 1'b1, 1'b1);

        apply_stimulus(OP_INCR, 8'h00, 8'h7F);
        @(negedge clock);
        apply_stimulus(OP_LSL, 8'h00, 8'h81);
        check_done("b2b_incr", 8'h80, 1'b0);
        @(negedge clock);
        apply_stimulus(OP_LSR, 8'h00, 8'h01);
        check_done("b2b_lsl", 8'h02, 1'b1);
        @(negedge clock);
        start = 1'b0;
        check_done("b2b_lsr", 8'h00, 1'b1);
        @(negedge clock);
        check_output("b2b_end_no_done", 8'(done), 8'd0);

        apply_stimulus(OP_ADD, 8'h80, 8'h90);
        @(negedge clock);
        start = 1'b0;
        check_done("pre_abort_add", 8'h10, 1'b1);

        apply_stimulus(OP_MUL, 8'd15, 8'd17);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check_output($sformatf("abort_busy_c%0d", k), 8'(busy), 8'd1);
            if (k < 4) @(negedge clock);
        end
        #1 reset_n = 1'b0;
        #1;
        check_output("abort_result", result, 8'h00);
        check_output("abort_flag", 8'(flag), 8'd0);
        check_output("abort_busy", 8'(busy), 8'd0);
        check_output("abort_done", 8'(done), 8'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check_output($sformatf("abort_hold%0d_done", k), 8'(done), 8'd0);
            check_output($sformatf("abort_hold%0d_busy", k), 8'(busy), 8'd0);
        end
        reset_n = 1'b1;
        apply_stimulus(OP_ADD, 8'h02, 8'h03);
        @(negedge clock);
        start = 1'b0;
        check_done("post_abort_add", 8'h05, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_output($sformatf("post_abort_quiet%0d", k), 8'(done), 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the datapath ALU. It executes single-cycle arithmetic, compare and shift operations, plus an iterative multi-cycle multiply, behind a start/busy/done handshake. It also holds the architectural flag register that conditional branches consume. It sits between the register-file read ports and the writeback mux; the decoder drives `op` directly.

## Interface
- `WIDTH`, default 8: operand and result width (≥2).
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled on the edge only when `busy`=0.
- `op` in 4: operation code; see `alu_pkg::op_t`.
- `in1` in WIDTH: operand A.
- `in2` in WIDTH: operand B.
- `busy` out 1: multiply in progress; new `start` is ignored.
- `done` out 1: one-cycle pulse; `result` and `flag` updated this cycle.
- `result` out WIDTH: registered result; holds between operations.
- `flag` out 1: registered flag (overflow/compare); holds between operations.

## Operation
- Reset values: `result`=0, `flag`=0, `busy`=0, `done`=0, state IDLE, iteration counter 0.
- Ops, as result / flag:
  - ADD: `in1`+`in2` mod 2^WIDTH / carry-out.
  - MATCH: result held / (`in1`==`in2`).
  - LT: result held / signed `in1` < signed `in2`.
  - DIST: |signed `in1` − signed `in2`|, computed at WIDTH+1 bits and emitted unsigned at WIDTH bits (always fits) / signed `in1` < signed `in2`.
  - LSL: `in2`<<1 / `in2`[MSB].
  - LSR: `in2`>>1 (logical) / `in2`[0].
  - INCR: `in2`+1 / carry-out.
  - AND1: result held / `in2`[0].
  - EQZ: result held / (`in2`==0).
  - ZERO: 0 / 0.
  - FLAG: zero-extended current flag / held.
  - MUL: low WIDTH bits of unsigned `in1`×`in2` / (high WIDTH bits ≠ 0).
  - Codes 12–15 (reserved): result held / flag held. `done` still pulses.
- FSM `alu_pkg::state_t`:
  - IDLE: accept `start`.
    - Non-MUL op: update `result` and `flag`, pulse `done`, stay in IDLE.
    - MUL: latch operands, clear accumulator, counter=0, go to MUL.
  - MUL: one shift-add iteration per edge; counter increments.
    - After iteration WIDTH: write `result` and `flag`, pulse `done`, return to IDLE.
- `start` while `busy`=1 is dropped silently; no queueing.
- Operands and `op` need only be valid on the accepting edge; MUL works from latched copies.
- `reset_n` low mid-MUL aborts immediately: accumulator is discarded and all outputs return to reset values.

## Timing
- Define accept edge N.
- Single-cycle op latency: 1. `result`, `flag` and `done` are valid in cycle N+1.
- Back-to-back single-cycle ops are accepted every cycle, giving `done` every cycle.
- MUL:
  - `busy`=1 in cycles N+1 … N+WIDTH.
  - `done`=1 in cycle N+WIDTH+1, with `busy`=0.
  - Earliest next accept is edge N+WIDTH+1.
- `done` is never high for two consecutive cycles from one op.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- Reset assertion acts asynchronously. Deassertion is synchronised upstream; the block needs no internal synchroniser.

## Structure
- `alu_pkg` contains:
  - `op_t`, a 4-bit enum in this order: ADD=0, MATCH, LT, DIST, LSL, LSR, INCR, AND1, EQZ, ZERO, MUL, FLAG.
  - `state_t` {IDLE, MUL}.
  - The reserved-code range.
- Sub-module `alu_mul_iter`:
  - Contains the WIDTH-parametrised shift-add datapath: multiplicand, multiplier shift register, 2·WIDTH accumulator and counter.
  - Signals: `load`, `step`, `last`, `product[2*WIDTH-1:0]`.
  - The FSM, single-cycle datapath and output registers live in `alu_seq`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → `result`=0x00, `flag`=0, `busy`=0, `done`=0.
- ADD 0xFF+0x01 → `result`=0x00, `flag`=1, `done` in cycle N+1. Then MATCH 0x5A,0x5A → `result` stays 0x00, `flag`=1.
- DIST `in1`=0x7F, `in2`=0x80 → `result`=0xFF, `flag`=0. DIST 0x80,0x7F → `result`=0xFF, `flag`=1.
- MUL 15×17 → `result`=0xFF, `flag`=0, `busy` for 8 cycles, `done` in cycle N+9. MUL 16×16 → `result`=0x00, `flag`=1.
- Back-to-back:
  - `start` asserted during a MUL with ADD 1+1 is ignored; `result` after `done` equals the product.
  - INCR 0x7F, LSL 0x81, LSR 0x01 on consecutive cycles → 0x80/0, 0x02/1, 0x00/1, with three consecutive `done` pulses.
- Reset mid-MUL at iteration 4 → outputs zero immediately and no `done` pulse. A new ADD 2+3 is accepted on the first edge after release → 0x05.
